// File: rtl/square_period_meter_pkg.sv
// -----------------------------------------------------------------------------
// square_period_meter_pkg
// Shared types and constants for the square wave period meter.
//   meter_state_e : FSM encoding (SEARCH = 0, MEASURE = 1)
//   SYNC_DEPTH    : number of synchronizer flops ahead of the edge detector
//   AVG_DEPTH     : number of periods averaged when PERIOD_AVG_EN is defined
//   AVG_SHIFT     : log2(AVG_DEPTH), the divide applied to the running sum
//   FILL_W        : width of the "periods collected" counter (holds 0..AVG_DEPTH)
// -----------------------------------------------------------------------------
package square_period_meter_pkg;

    typedef enum logic {
        SEARCH  = 1'b0,
        MEASURE = 1'b1
    } meter_state_e;

    localparam int SYNC_DEPTH = 2;
    localparam int AVG_DEPTH  = 4;
    localparam int AVG_SHIFT  = 2;
    localparam int FILL_W     = 3;

endpackage : square_period_meter_pkg

// File: rtl/square_period_meter_edge_sync.sv
// -----------------------------------------------------------------------------
// edge_sync
// Brings one asynchronous input into the clk domain through a sync_depth-deep
// flop chain, keeps one more flop of history and flags the 0->1 transition.
// With sync_depth = 2 the rise flag is registered by the consumer three clk
// edges after the input changes.
//
// Ports
//   clk_i    in   system clock
//   reset_i  in   synchronous active-high reset (clears chain and history)
//   d_i      in   asynchronous input bit
//   rise_o   out  combinational rising-edge flag, one cycle wide
// -----------------------------------------------------------------------------
module edge_sync #(
    parameter int sync_depth = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic rise_o
);

    logic [sync_depth-1:0] sync_q;
    logic                  prev_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[sync_depth-2:0], d_i};
            prev_q <= sync_q[sync_depth-1];
        end
    end

    assign rise_o = sync_q[sync_depth-1] & ~prev_q;

endmodule : edge_sync

// File: rtl/square_period_meter.sv
// -----------------------------------------------------------------------------
// square_period_meter
// Measures the period of an incoming square wave in clk cycles (rise to rise).
// Each accepted period is reported on period_out with a one-cycle period_valid
// strobe. Rises closer than min_period to the previous accepted rise are
// treated as glitches and ignored. If no rise arrives before the counter
// reaches its maximum, the meter drops lock and returns to SEARCH.
//
// Build option
//   PERIOD_AVG_EN : when defined, period_out is the mean of the last four
//                   accepted periods and the strobe only fires once four
//                   periods have been collected since lock.
//
// Ports
//   clk           in   system clock
//   reset         in   synchronous active-high reset
//   wave_in       in   square wave sample bus, only the MSB is used
//   period_out    out  last accepted (or averaged) period, 0 when unlocked
//   period_valid  out  one-cycle strobe, period_out updates in the same cycle
//   locked        out  high while valid periods are being measured
//   no_signal     out  high from reset/timeout until the first accepted period
//
// State table
//   state   | meaning
//   SEARCH  | waiting for a first rise to arm the measurement, counter at 0
//   MEASURE | counting clk cycles since the last accepted (or arming) rise
// -----------------------------------------------------------------------------
module square_period_meter
    import square_period_meter_pkg::*;
#(
    parameter int resolution_bits = 8,
    parameter int counter_width   = 16,
    parameter int min_period      = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [resolution_bits-1:0] wave_in,
    output logic [counter_width-1:0]   period_out,
    output logic                       period_valid,
    output logic                       locked,
    output logic                       no_signal
);

    // Compare values carry one extra bit so count+1 never wraps.
    localparam logic [counter_width:0]   CNT_MAX = {1'b0, {counter_width{1'b1}}};
    localparam logic [counter_width:0]   MIN_P   = (counter_width+1)'(min_period);
    localparam logic [counter_width-1:0] CNT_SAT = '1;

    meter_state_e               state_q, state_d;
    logic [counter_width-1:0]   count_q, count_d;
    logic [counter_width-1:0]   period_q, period_d;
    logic                       valid_q, valid_d;
    logic                       locked_q, locked_d;
    logic                       nosig_q, nosig_d;

    logic                       rise;
    logic [counter_width:0]     count_inc;
    logic [counter_width-1:0]   new_period;
    logic                       accept;
    logic                       timeout;

    // Only the MSB of the sample bus carries the square wave.
    logic                       wave_low_unused;
    assign wave_low_unused = &{1'b0, wave_in};

    edge_sync #(
        .sync_depth (SYNC_DEPTH)
    ) u_edge_sync (
        .clk_i   (clk),
        .reset_i (reset),
        .d_i     (wave_in[resolution_bits-1]),
        .rise_o  (rise)
    );

    assign count_inc  = {1'b0, count_q} + 1'b1;
    assign new_period = count_inc[counter_width-1:0];
    assign accept     = rise && (count_inc >= MIN_P);
    // Timeout fires on the cycle the counter would reach its maximum; an
    // accepted rise in that same cycle takes priority and reports CNT_MAX.
    assign timeout    = (count_inc == CNT_MAX);

`ifdef PERIOD_AVG_EN
    localparam int SUM_W = counter_width + 2;

    logic [counter_width-1:0] hist_q [AVG_DEPTH];
    logic [counter_width-1:0] hist_d [AVG_DEPTH];
    logic [SUM_W-1:0]         sum_q, sum_d;
    logic [FILL_W-1:0]        fill_q, fill_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= SEARCH;
            count_q  <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            nosig_q  <= 1'b1;
`ifdef PERIOD_AVG_EN
            for (int i = 0; i < AVG_DEPTH; i++) begin
                hist_q[i] <= '0;
            end
            sum_q    <= '0;
            fill_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
            nosig_q  <= nosig_d;
`ifdef PERIOD_AVG_EN
            hist_q   <= hist_d;
            sum_q    <= sum_d;
            fill_q   <= fill_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        period_d = period_q;
        valid_d  = 1'b0;
        locked_d = locked_q;
        nosig_d  = nosig_q;
`ifdef PERIOD_AVG_EN
        hist_d   = hist_q;
        sum_d    = sum_q;
        fill_d   = fill_q;
`endif

        case (state_q)
            SEARCH: begin
                // The arming rise starts the interval but produces no report.
                count_d = '0;
                if (rise) begin
                    state_d = MEASURE;
                end
            end

            MEASURE: begin
                count_d = (count_q == CNT_SAT) ? count_q : new_period;

                if (accept) begin
                    count_d  = '0;
                    locked_d = 1'b1;
                    nosig_d  = 1'b0;
`ifdef PERIOD_AVG_EN
                    // Oldest entry is zero until the history is full, so the
                    // running sum stays exact while it fills.
                    for (int i = AVG_DEPTH - 1; i > 0; i--) begin
                        hist_d[i] = hist_q[i-1];
                    end
                    hist_d[0] = new_period;
                    sum_d = sum_q + SUM_W'(new_period) - SUM_W'(hist_q[AVG_DEPTH-1]);
                    if (fill_q >= FILL_W'(AVG_DEPTH - 1)) begin
                        valid_d  = 1'b1;
                        period_d = sum_d[SUM_W-1:AVG_SHIFT];
                    end
                    if (fill_q < FILL_W'(AVG_DEPTH)) begin
                        fill_d = fill_q + FILL_W'(1);
                    end
`else
                    valid_d  = 1'b1;
                    period_d = new_period;
`endif
                end else if (timeout) begin
                    state_d  = SEARCH;
                    count_d  = '0;
                    period_d = '0;
                    locked_d = 1'b0;
                    nosig_d  = 1'b1;
`ifdef PERIOD_AVG_EN
                    for (int i = 0; i < AVG_DEPTH; i++) begin
                        hist_d[i] = '0;
                    end
                    sum_d  = '0;
                    fill_d = '0;
`endif
                end
            end

            default: begin
                state_d = SEARCH;
                count_d = '0;
            end
        endcase
    end

    assign period_out   = period_q;
    assign period_valid = valid_q;
    assign locked       = locked_q;
    assign no_signal    = nosig_q;

endmodule : square_period_meter

// File: tb/tb_square_period_meter.sv
// -----------------------------------------------------------------------------
// tb_square_period_meter
// Directed stimulus for square_period_meter (counter_width = 8, min_period = 4).
// A cycle-indexed behavioural model predicts the outputs from rise times and
// interval arithmetic; a negedge process compares every cycle after reset.
// Literal checks after each segment pin the model to hand-computed values.
// Honours PERIOD_AVG_EN when the design is built with it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_square_period_meter;

    localparam int RB   = 8;
    localparam int CW   = 8;
    localparam int MINP = 4;
    localparam int CMAX = (1 << CW) - 1;
`ifdef PERIOD_AVG_EN
    localparam int AVG = 1;
`else
    localparam int AVG = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [RB-1:0] wave_in = '0;
    logic [CW-1:0] period_out;
    logic          period_valid;
    logic          locked;
    logic          no_signal;

    square_period_meter #(
        .resolution_bits (RB),
        .counter_width   (CW),
        .min_period      (MINP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wave_in      (wave_in),
        .period_out   (period_out),
        .period_valid (period_valid),
        .locked       (locked),
        .no_signal    (no_signal)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The wave MSB reaches the rise decision three edges after it is sampled:
    // a rise is seen at edge n when the wave was 1 at edge n-2 and 0 at n-3.
    int  cyc = 0;
    bit  live = 0;
    bit  w1 = 0, w2 = 0, w3 = 0;
    bit  seen_rise;
    bit  armed = 0;
    int  last_rise = 0;
    int  acc_q[$];
    int  m_period = 0;
    bit  m_valid = 0, m_locked = 0, m_nosig = 1;

    function automatic int avg4();
        int s = 0;
        foreach (acc_q[i]) s += acc_q[i];
        return s / 4;
    endfunction

    always @(posedge clk) begin
        cyc++;
        m_valid = 0;
        if (reset) begin
            live = 1;
            w1 = 0; w2 = 0; w3 = 0;
            armed = 0;
            acc_q.delete();
            m_period = 0; m_locked = 0; m_nosig = 1;
        end else begin
            seen_rise = w2 && !w3;
            if (!armed) begin
                if (seen_rise) begin
                    armed = 1;
                    last_rise = cyc;
                end
            end else if (seen_rise && (cyc - last_rise) >= MINP) begin
                m_locked = 1;
                m_nosig  = 0;
                if (AVG != 0) begin
                    acc_q.push_back(cyc - last_rise);
                    if (acc_q.size() > 4) void'(acc_q.pop_front());
                    if (acc_q.size() == 4) begin
                        m_valid  = 1;
                        m_period = avg4();
                    end
                end else begin
                    m_valid  = 1;
                    m_period = cyc - last_rise;
                end
                last_rise = cyc;
            end else if ((cyc - last_rise) == CMAX) begin
                armed = 0;
                acc_q.delete();
                m_period = 0; m_locked = 0; m_nosig = 1;
            end
            w3 = w2; w2 = w1; w1 = wave_in[RB-1];
        end
    end

    // ---------------- compare + strobe log ----------------
    int strobes[$];
    int last_strobe_cyc = 0;
    int lock_drop_cyc   = -1;
    bit locked_prev     = 0;

    always @(negedge clk) begin
        if (live) begin
            chk("period_valid", int'(period_valid), int'(m_valid));
            chk("period_out",   int'(period_out),   m_period);
            chk("locked",       int'(locked),       int'(m_locked));
            chk("no_signal",    int'(no_signal),    int'(m_nosig));
            if (period_valid) begin
                strobes.push_back(int'(period_out));
                last_strobe_cyc = cyc;
            end
            if (locked_prev && !locked) lock_drop_cyc = cyc;
            locked_prev = locked;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit v);
        wave_in = {v, 7'($urandom)};
        @(posedge clk);
        #1;
    endtask

    task automatic hl(input int hi, input int lo, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < hi; i++) step(1'b1);
            for (int i = 0; i < lo; i++) step(1'b0);
        end
    endtask

    task automatic glitch_period();
        step(1'b1); step(1'b0); step(1'b1);
        for (int i = 0; i < 5; i++) step(1'b0);
    endtask

    int base;

    initial begin
        reset = 1'b1;
        step(1'b0); step(1'b0); step(1'b0);
        reset = 1'b0;
        chk("rst_period_out", int'(period_out), 0);
        chk("rst_locked",     int'(locked),     0);
        chk("rst_no_signal",  int'(no_signal),  1);
        step(1'b0); step(1'b0);

        // steady 4 high / 4 low
        base = strobes.size();
        hl(4, 4, 6);
        chk("p8_count",     strobes.size() - base, (AVG != 0) ? 2 : 5);
        chk("p8_value",     strobes[$], 8);
        chk("p8_locked",    int'(locked), 1);
        chk("p8_no_signal", int'(no_signal), 0);

        // transitional interval of 6, then period 20
        base = strobes.size();
        hl(4, 2, 1);
        hl(10, 10, 3);
        step(1'b1);
        for (int i = 0; i < 6; i++) step(1'b0);
        chk("chg_count",      strobes.size() - base, 5);
        chk("chg_transition", strobes[base+1], (AVG != 0) ? 7 : 6);
        chk("chg_settled",    strobes[base+3], (AVG != 0) ? 13 : 20);
        chk("chg_last",       strobes[base+4], (AVG != 0) ? 16 : 20);

        // wave held low: timeout CMAX cycles after the last accepted rise
        for (int i = 0; i < 300; i++) step(1'b0);
        chk("to_delay",     lock_drop_cyc - last_strobe_cyc, CMAX);
        chk("to_period",    int'(period_out), 0);
        chk("to_locked",    int'(locked), 0);
        chk("to_no_signal", int'(no_signal), 1);

        // period 8 with a 1-clk glitch 2 cycles after each rise
        base = strobes.size();
        hl(4, 4, 2);
        for (int i = 0; i < 3; i++) glitch_period();
        step(1'b1);
        for (int i = 0; i < 6; i++) step(1'b0);
        chk("gl_count", strobes.size() - base, (AVG != 0) ? 2 : 5);
        chk("gl_first", strobes[base], 8);
        chk("gl_last",  strobes[$], 8);

        // 1-clk reset in the low half of a period
        hl(4, 2, 1);
        reset = 1'b1;
        step(1'b0);
        reset = 1'b0;
        chk("mr_period_out", int'(period_out), 0);
        chk("mr_valid",      int'(period_valid), 0);
        chk("mr_locked",     int'(locked), 0);
        chk("mr_no_signal",  int'(no_signal), 1);
        step(1'b0);
        base = strobes.size();
        hl(4, 4, 3);
        step(1'b0); step(1'b0);
        chk("mr_count",  strobes.size() - base, (AVG != 0) ? 0 : 2);
        chk("mr_last",   strobes[$], 8);
        chk("mr_locked2", int'(locked), 1);

        // periods 8, 8, 12, 12
        reset = 1'b1;
        step(1'b0);
        reset = 1'b0;
        step(1'b0); step(1'b0);
        base = strobes.size();
        hl(4, 4, 2);
        hl(6, 6, 2);
        step(1'b1);
        for (int i = 0; i < 6; i++) step(1'b0);
        chk("avg_count", strobes.size() - base, (AVG != 0) ? 1 : 4);
        chk("avg_value", strobes[$], (AVG != 0) ? 10 : 12);

        step(1'b0); step(1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_square_period_meter
